// File: rtl/mgt_01_nonrestoring_divider_pkg.sv
// Shared types and constants for the radix-2 non-restoring divider.
// The operand width lives here so the P/A register pair struct matches the datapath.
package mgt_01_nonrestoring_divider_pkg;

    localparam int DIV_XLEN = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIVIDE   = 2'd1,
        FINALIZE = 2'd2,
        VALID    = 2'd3
    } div_fsm_state_e;

    // P is the signed partial remainder, A collects the quotient as it shifts out the dividend
    typedef struct packed {
        logic [DIV_XLEN:0]   p;
        logic [DIV_XLEN-1:0] a;
    } div_reg_pair_s;

    localparam logic [DIV_XLEN-1:0] DIV_BY_ZERO_QUOTIENT = '1;

endpackage

// File: rtl/mgt_01_div_sign_fix.sv
// Sign handling around the unsigned divide core: operand magnitudes at entry,
// and quotient/remainder negation when the result is finalized.
module mgt_01_div_sign_fix #(
    parameter int W = 32
) (
    input  logic         i_signed,
    input  logic [W-1:0] i_dividend,
    input  logic [W-1:0] i_divisor,
    input  logic         i_dvd_neg,
    input  logic         i_dvs_neg,
    input  logic [W-1:0] i_quot_mag,
    input  logic [W-1:0] i_rem_mag,
    output logic         o_dividend_neg,
    output logic         o_divisor_neg,
    output logic [W-1:0] o_dividend_abs,
    output logic [W-1:0] o_divisor_abs,
    output logic [W-1:0] o_quotient,
    output logic [W-1:0] o_remainder
);

    assign o_dividend_neg = i_signed & i_dividend[W-1];
    assign o_divisor_neg  = i_signed & i_divisor[W-1];

    // The magnitude of the most negative value wraps to itself, which is correct read as unsigned
    assign o_dividend_abs = o_dividend_neg ? (~i_dividend + 1'b1) : i_dividend;
    assign o_divisor_abs  = o_divisor_neg  ? (~i_divisor  + 1'b1) : i_divisor;

    assign o_quotient  = (i_dvd_neg ^ i_dvs_neg) ? (~i_quot_mag + 1'b1) : i_quot_mag;
    assign o_remainder = i_dvd_neg ? (~i_rem_mag + 1'b1) : i_rem_mag;

endmodule

// File: rtl/mgt_01_nonrestoring_divider.sv
// Sequential radix-2 non-restoring divider with RISC-V divide-by-zero and overflow results.
// valid_o is a one-enabled-cycle pulse; start_i is taken only in IDLE with clk_en_i high.
module mgt_01_nonrestoring_divider
    import mgt_01_nonrestoring_divider_pkg::*;
#(
    parameter int XLEN  = DIV_XLEN,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            clk_en_i,
    input  logic            start_i,
    input  logic            signed_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o,
    output logic            valid_o,
    output logic            busy_o,
    output logic            div_by_zero_o
);

    div_fsm_state_e  r_state;
    div_fsm_state_e  w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    div_reg_pair_s   r_pa;
    logic [XLEN:0]   r_b;
    logic            r_dvd_neg;
    logic            r_dvs_neg;
    logic [XLEN-1:0] r_quot;
    logic [XLEN-1:0] r_rem;
    logic            r_dbz;

    logic            w_div_zero;
    logic            w_overflow;
    logic            w_last_iter;
    logic            w_dvd_neg;
    logic            w_dvs_neg;
    logic [XLEN-1:0] w_dvd_abs;
    logic [XLEN-1:0] w_dvs_abs;
    logic [XLEN:0]   w_p_sh;
    logic [XLEN:0]   w_p_step;
    logic [XLEN-1:0] w_rem_mag;
    logic [XLEN-1:0] w_quot_fix;
    logic [XLEN-1:0] w_rem_fix;

    mgt_01_div_sign_fix #(.W(XLEN)) u_sign_fix (
        .i_signed       (signed_i),
        .i_dividend     (dividend_i),
        .i_divisor      (divisor_i),
        .i_dvd_neg      (r_dvd_neg),
        .i_dvs_neg      (r_dvs_neg),
        .i_quot_mag     (r_pa.a),
        .i_rem_mag      (w_rem_mag),
        .o_dividend_neg (w_dvd_neg),
        .o_divisor_neg  (w_dvs_neg),
        .o_dividend_abs (w_dvd_abs),
        .o_divisor_abs  (w_dvs_abs),
        .o_quotient     (w_quot_fix),
        .o_remainder    (w_rem_fix)
    );

    assign w_div_zero  = (divisor_i == '0);
    assign w_overflow  = signed_i && (dividend_i == {1'b1, {(XLEN-1){1'b0}}}) && (divisor_i == '1);
    assign w_last_iter = (r_cnt == CNT_W'(XLEN-1));

    // One iteration: shift {P,A} left, then subtract or add B depending on the sign of P before the shift
    assign w_p_sh   = {r_pa.p[XLEN-1:0], r_pa.a[XLEN-1]};
    assign w_p_step = r_pa.p[XLEN] ? (w_p_sh + r_b) : (w_p_sh - r_b);

    // The corrected remainder is non-negative and below B, so the low XLEN bits carry it exactly
    assign w_rem_mag = r_pa.p[XLEN] ? (r_pa.p[XLEN-1:0] + r_b[XLEN-1:0]) : r_pa.p[XLEN-1:0];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
        end else if (clk_en_i) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_state_nxt = (w_div_zero || w_overflow) ? VALID : DIVIDE;
                end
            end
            DIVIDE: begin
                if (w_last_iter) begin
                    w_state_nxt = FINALIZE;
                end
            end
            FINALIZE: w_state_nxt = VALID;
            VALID:    w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt     <= '0;
            r_pa      <= '0;
            r_b       <= '0;
            r_dvd_neg <= 1'b0;
            r_dvs_neg <= 1'b0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_dbz     <= 1'b0;
        end else if (clk_en_i) begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_cnt     <= '0;
                        r_pa.p    <= '0;
                        r_pa.a    <= w_dvd_abs;
                        r_b       <= {1'b0, w_dvs_abs};
                        r_dvd_neg <= w_dvd_neg;
                        r_dvs_neg <= w_dvs_neg;
                        r_dbz     <= 1'b0;
                        if (w_div_zero) begin
                            r_quot <= DIV_BY_ZERO_QUOTIENT;
                            r_rem  <= dividend_i;
                            r_dbz  <= 1'b1;
                        end else if (w_overflow) begin
                            r_quot <= dividend_i;
                            r_rem  <= '0;
                        end
                    end
                end
                DIVIDE: begin
                    r_pa.p <= w_p_step;
                    r_pa.a <= {r_pa.a[XLEN-2:0], ~w_p_step[XLEN]};
                    r_cnt  <= r_cnt + CNT_W'(1);
                end
                FINALIZE: begin
                    r_quot <= w_quot_fix;
                    r_rem  <= w_rem_fix;
                end
                default: ;
            endcase
        end
    end

    assign quotient_o    = r_quot;
    assign remainder_o   = r_rem;
    assign div_by_zero_o = r_dbz;
    assign valid_o       = (r_state == VALID);
    assign busy_o        = (r_state != IDLE);

endmodule

// File: tb/tb_mgt_01_nonrestoring_divider.sv
// Self-checking bench for the non-restoring divider: reference model feeds an
// expected queue at drive time, results are popped and compared on valid_o.
module tb_mgt_01_nonrestoring_divider;

    localparam int W       = 32;
    localparam int MAX_LAT = 200;

    logic         clk_i;
    logic         rst_n_i;
    logic         clk_en_i;
    logic         start_i;
    logic         signed_i;
    logic [W-1:0] dividend_i;
    logic [W-1:0] divisor_i;
    logic [W-1:0] quotient_o;
    logic [W-1:0] remainder_o;
    logic         valid_o;
    logic         busy_o;
    logic         div_by_zero_o;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_quot_q[$];
    logic [W-1:0] exp_rem_q[$];
    logic [W-1:0] exp_dbz_q[$];
    logic [W-1:0] exp_lat_q[$];

    mgt_01_nonrestoring_divider dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .clk_en_i      (clk_en_i),
        .start_i       (start_i),
        .signed_i      (signed_i),
        .dividend_i    (dividend_i),
        .divisor_i     (divisor_i),
        .quotient_o    (quotient_o),
        .remainder_o   (remainder_o),
        .valid_o       (valid_o),
        .busy_o        (busy_o),
        .div_by_zero_o (div_by_zero_o)
    );

    // clock / reset
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // RISC-V M-extension reference, latency counted from the accept edge
    task automatic model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic dz, output int lat);
        dz = 1'b0;
        if (b == '0) begin
            q = '1; r = a; dz = 1'b1; lat = 1;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a; r = '0; lat = 1;
        end else if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
            lat = W + 2;
        end else begin
            q = a / b; r = a % b; lat = W + 2;
        end
    endtask

    // Called at a negedge; returns at a negedge with the DUT back in IDLE
    task automatic run_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int stall_at, input int stall_len, input bit spam);
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           lat;
        int           obs_lat;
        bit           busy_bad;
        model(s, a, b, q, r, dz, lat);
        exp_quot_q.push_back(q);
        exp_rem_q.push_back(r);
        exp_dbz_q.push_back({{(W-1){1'b0}}, dz});
        exp_lat_q.push_back(W'(lat + stall_len));

        signed_i   = s;
        dividend_i = a;
        divisor_i  = b;
        start_i    = 1'b1;
        @(posedge clk_i);
        obs_lat  = 1;
        busy_bad = 1'b0;
        @(negedge clk_i);
        start_i = 1'b0;
        while (!valid_o && obs_lat < MAX_LAT) begin
            if (!busy_o) busy_bad = 1'b1;
            if (stall_len > 0 && obs_lat == stall_at) clk_en_i = 1'b0;
            if (stall_len > 0 && obs_lat == stall_at + stall_len) clk_en_i = 1'b1;
            if (spam && obs_lat == 3) begin
                start_i    = 1'b1;
                signed_i   = ~s;
                dividend_i = $urandom;
                divisor_i  = '0;
            end
            if (spam && obs_lat == 5) start_i = 1'b0;
            @(posedge clk_i);
            obs_lat++;
            @(negedge clk_i);
        end
        clk_en_i = 1'b1;
        start_i  = 1'b0;
        if (!valid_o) check_val("valid_timeout", W'(obs_lat), exp_lat_q[0]);
        check_val("quotient",  quotient_o,            exp_quot_q.pop_front());
        check_val("remainder", remainder_o,           exp_rem_q.pop_front());
        check_val("div_zero",  W'(div_by_zero_o),     exp_dbz_q.pop_front());
        check_val("latency",   W'(obs_lat),           exp_lat_q.pop_front());
        check_val("busy_hold", W'(busy_bad | !busy_o), '0);
        @(posedge clk_i);
        @(negedge clk_i);
        check_val("valid_pulse", W'({valid_o, busy_o}), '0);
    endtask

    initial begin
        bit saw_valid;
        rst_n_i    = 1'b0;
        clk_en_i   = 1'b1;
        start_i    = 1'b0;
        signed_i   = 1'b0;
        dividend_i = '0;
        divisor_i  = '0;
        repeat (3) @(negedge clk_i);
        check_val("rst_quot", quotient_o, '0);
        check_val("rst_flags", W'({remainder_o != '0, valid_o, busy_o, div_by_zero_o}), '0);
        rst_n_i = 1'b1;
        @(negedge clk_i);

        run_div(1'b0, 32'd100, 32'd7, 0, 0, 1'b0);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 0, 1'b0);
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 0, 0, 1'b0);
        run_div(1'b1, 32'd5, 32'd0, 0, 0, 1'b0);
        run_div(1'b0, 32'd5, 32'd0, 0, 0, 1'b0);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1'b0);
        run_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1'b0);
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 10, 5, 1'b1);
        run_div(1'b1, 32'h8000_0000, 32'd3, 0, 0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] b;
            b = (i < 4) ? W'($urandom_range(1, 1000)) : $urandom;
            if (b == '0) b = 32'd1;
            run_div(1'(i % 2), $urandom, b, 0, 0, 1'b0);
        end

        // leave nonzero outputs behind, then abort a division with reset
        run_div(1'b0, 32'd5, 32'd0, 0, 0, 1'b0);
        signed_i   = 1'b0;
        dividend_i = 32'hFFFF_FFFF;
        divisor_i  = 32'd3;
        start_i    = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (9) @(negedge clk_i);
        rst_n_i = 1'b0;
        #1;
        check_val("abort_quot", quotient_o, '0);
        check_val("abort_rem", remainder_o, '0);
        check_val("abort_flags", W'({valid_o, busy_o, div_by_zero_o}), '0);
        @(negedge clk_i);
        rst_n_i   = 1'b1;
        saw_valid = 1'b0;
        repeat (40) begin
            @(negedge clk_i);
            if (valid_o || busy_o) saw_valid = 1'b1;
        end
        check_val("abort_no_valid", W'(saw_valid), '0);
        run_div(1'b0, 32'd9, 32'd3, 0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mgt_01_nonrestoring_divider.md
Name: mgt_01_nonrestoring_divider

Overview:
- Sequential radix-2 non-restoring integer divider. It is the inverse companion of the iterative Booth multiplier in the arithmetic unit.
- Serves DIV/DIVU/REM/REMU and is reused for low-performance mantissa division in the FPU.
- Produces one quotient bit per enabled cycle, with the same clock-enable gating and valid-pulse style as the multiplier.
- Applies RISC-V M-extension rules for divide-by-zero and signed overflow.

Parameters:
- XLEN, 32, operand/result width; power of two, ≥ 4.
- CNT_W, $clog2(XLEN), iteration counter width; derived, not overridden.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  reset; asynchronous, active-low.
- clk_en_i  in  1  clock enable; when low, all state, counters and outputs hold.
- start_i  in  1  request; accepted only in IDLE with clk_en_i=1.
- signed_i  in  1  1 = two's-complement operands (DIV/REM); 0 = unsigned.
- dividend_i  in  XLEN  dividend; sampled on accept.
- divisor_i  in  XLEN  divisor; sampled on accept.
- quotient_o  out  XLEN  registered quotient; holds until the next result.
- remainder_o  out  XLEN  registered remainder; sign follows the dividend.
- valid_o  out  1  one-enabled-cycle pulse; results valid while high.
- busy_o  out  1  high in any state other than IDLE.
- div_by_zero_o  out  1  qualified by valid_o; divisor was 0.

Behaviour:
- Reset (async, any state): FSM to IDLE; counter 0. quotient_o, remainder_o, valid_o, busy_o and div_by_zero_o all 0.
- States: IDLE, DIVIDE, FINALIZE, VALID.
- IDLE, on start_i & clk_en_i:
  - Latch the operands and signed_i.
  - If divisor==0 → VALID (special path).
  - Else if signed_i & dividend==2^(XLEN-1) & divisor==all-ones → VALID (overflow path).
  - Else:
    - Store |dividend| in the A register.
    - Store |divisor| in a (XLEN+1)-bit B register.
    - Clear the (XLEN+1)-bit partial remainder P; clear the counter.
    - → DIVIDE.
- DIVIDE, per enabled cycle:
  - Shift {P,A} left by 1.
  - If P (before shift) ≥ 0, then P = P − B; else P = P + B.
  - A[0] = ~P_new[XLEN].
  - Counter +1. When counter == XLEN−1, take this last iteration and go → FINALIZE.
- FINALIZE, one enabled cycle:
  - If P < 0, then P = P + B (remainder correction).
  - Quotient = A. Negate the quotient if signed_i & (sign dividend ≠ sign divisor).
  - Negate the remainder if signed_i & dividend negative.
  - Register both to the outputs. → VALID.
- VALID: valid_o=1 for one enabled cycle → IDLE.
- Special-path results are written on the accept edge:
  - Divide-by-zero: quotient all-ones, remainder = dividend, div_by_zero_o=1.
  - Overflow: quotient = dividend, remainder 0.
- Latency in enabled cycles, accept edge to valid_o high:
  - Normal path: XLEN+2 (34 for XLEN=32).
  - Special paths: 1.
  - Every cycle with clk_en_i=0 extends the latency by 1, with no state change.
- start_i while busy is ignored. No queueing.
- A back-to-back start is accepted in the IDLE cycle directly after VALID. There is no bubble beyond that.
- Reset mid-operation aborts the division. Outputs go to 0; no valid_o.
- div_by_zero_o is cleared on every accept.
- Arithmetic widths:
  - P is XLEN+1 bits signed.
  - |x| of 2^(XLEN-1) is handled as unsigned XLEN bits; no overflow.

Decomposition:
- Shared package (Modules_pkg) holds:
  - div_fsm_state_e {IDLE, DIVIDE, FINALIZE, VALID}.
  - Packed struct div_reg_pair_s {P[XLEN:0], A[XLEN-1:0]}.
  - Constant DIV_BY_ZERO_QUOTIENT = all-ones.
- One combinational sub-module is natural: mgt_01_div_sign_fix. It does the operand absolute value and the result negation, and is used at entry and in FINALIZE.
- The add/sub step stays inline.

Test Plan:
1. Unsigned: signed_i=0, 100 / 7 → quotient 14, remainder 2. valid_o exactly 34 cycles after accept; busy_o high throughout.
2. Signed: −7 / 2 → quotient 0xFFFFFFFD (−3), remainder 0xFFFFFFFF (−1). Also 7 / −2 → quotient −3, remainder 1.
3. Divide-by-zero: 5 / 0 (both modes) → quotient 0xFFFFFFFF, remainder 5, div_by_zero_o=1. valid_o 1 cycle after accept.
4. Overflow: signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0, valid 1 cycle later. The same operands unsigned → quotient 0, remainder 0x80000000 after 34 cycles.
5. Clock-enable stall: 0xFFFFFFFF / 1 unsigned, clk_en_i low for 5 cycles mid-DIVIDE → valid_o after 39 cycles; quotient 0xFFFFFFFF, remainder 0. start_i pulses while busy are ignored.
6. Reset abort: assert rst_n_i at cycle 10 of a division → outputs 0 immediately (async), no valid_o. A new 9 / 3 after release → quotient 3, remainder 0.
